// File: rtl/risc32_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : risc32_bus_arbiter
// Brief    : Shares the external memory bus between IF and MEM ports, fixed
//            priority MEM over IF, one outstanding transaction at a time.
//            Optional bus timeout: define RISC32_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module risc32_bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        bus_err
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_gnt_if  = 2'd1;
    localparam logic [1:0] c_st_gnt_mem = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = c_st_idle,
        ST_GNT_IF  = c_st_gnt_if,
        ST_GNT_MEM = c_st_gnt_mem
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_bus_req, w_bus_req_nxt;
    logic        r_bus_we, w_bus_we_nxt;
    logic [3:0]  r_bus_sel, w_bus_sel_nxt;
    logic [31:0] r_bus_addr, w_bus_addr_nxt;
    logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [31:0] r_if_rdata, w_if_rdata_nxt;
    logic [31:0] r_mem_rdata, w_mem_rdata_nxt;
    logic        r_if_ready, w_if_ready_nxt;
    logic        r_mem_ready, w_mem_ready_nxt;
    logic        w_fin;
    logic        w_fin_err;
    logic [31:0] w_fin_data;
    logic        w_if_elig;
    logic        w_mem_elig;

`ifdef RISC32_ARB_TIMEOUT_EN
    localparam logic [7:0] c_limit = 8'(TIMEOUT - 1);
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_bus_err, w_bus_err_nxt;
`endif

    // A port in its ready cycle still holds req high; it must not be regranted.
    assign w_if_elig  = if_req  & ~r_if_ready;
    assign w_mem_elig = mem_req & ~r_mem_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_sel_nxt   = r_bus_sel;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_mem_rdata_nxt = r_mem_rdata;
        w_if_ready_nxt  = 1'b0;
        w_mem_ready_nxt = 1'b0;
        w_fin           = 1'b0;
        w_fin_err       = 1'b0;
        w_fin_data      = bus_rdata;
`ifdef RISC32_ARB_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
        w_bus_err_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_mem_elig) begin
                    w_state_nxt     = ST_GNT_MEM;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = mem_we;
                    w_bus_sel_nxt   = mem_sel;
                    w_bus_addr_nxt  = mem_addr;
                    w_bus_wdata_nxt = mem_wdata;
`ifdef RISC32_ARB_TIMEOUT_EN
                    w_cnt_nxt       = 8'd0;
`endif
                end else if (w_if_elig) begin
                    w_state_nxt     = ST_GNT_IF;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_sel_nxt   = 4'b1111;
                    w_bus_addr_nxt  = if_addr;
                    w_bus_wdata_nxt = 32'd0;
`ifdef RISC32_ARB_TIMEOUT_EN
                    w_cnt_nxt       = 8'd0;
`endif
                end
            end
            ST_GNT_IF, ST_GNT_MEM: begin
                w_fin = bus_ack;
`ifdef RISC32_ARB_TIMEOUT_EN
                // An ack arriving on the limit cycle takes precedence over the abort.
                if (!bus_ack) begin
                    if (r_cnt == c_limit) begin
                        w_fin      = 1'b1;
                        w_fin_err  = 1'b1;
                        w_fin_data = 32'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
`endif
                if (w_fin) begin
                    w_state_nxt   = ST_IDLE;
                    w_bus_req_nxt = 1'b0;
                    if (r_state == ST_GNT_IF) begin
                        w_if_rdata_nxt = w_fin_data;
                        w_if_ready_nxt = 1'b1;
                    end else begin
                        w_mem_rdata_nxt = w_fin_data;
                        w_mem_ready_nxt = 1'b1;
                    end
`ifdef RISC32_ARB_TIMEOUT_EN
                    w_bus_err_nxt = w_fin_err;
`endif
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bus_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'd0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
`ifdef RISC32_ARB_TIMEOUT_EN
            r_cnt       <= 8'd0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_mem_ready <= w_mem_ready_nxt;
`ifdef RISC32_ARB_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
            r_bus_err   <= w_bus_err_nxt;
`endif
        end
    end

    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_sel      = r_bus_sel;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign if_rdata     = r_if_rdata;
    assign mem_rdata    = r_mem_rdata;
    assign if_ready     = r_if_ready;
    assign mem_ready    = r_mem_ready;
    assign stallreq_if  = if_req  & ~r_if_ready;
    assign stallreq_mem = mem_req & ~r_mem_ready;

`ifdef RISC32_ARB_TIMEOUT_EN
    assign bus_err = r_bus_err;
`else
    // Constant 0 for any legal TIMEOUT; no abort path exists in this build.
    assign bus_err = (TIMEOUT < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_risc32_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_risc32_bus_arbiter
// Brief    : Scoreboard bench for risc32_bus_arbiter with a simple bus slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc32_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        bus_err;

    always #5 clk = ~clk;

    risc32_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        bit          chk_wd;
        int          len;      // expected bus_req cycles, 0 = not checked
    } bus_t;

    typedef struct {
        bit          port;     // 0 = IF, 1 = MEM
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_t        bus_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] slave_q[$];
    int          slave_wait;
    int          tests;
    int          fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic exp_if(input logic [31:0] a, input logic [31:0] d, input int len);
        bus_t b;
        rsp_t r;
        b.addr = a; b.we = 1'b0; b.sel = 4'b1111; b.wdata = 32'd0; b.chk_wd = 1'b0; b.len = len;
        r.port = 1'b0; r.rdata = d; r.err = 1'b0;
        bus_q.push_back(b);
        rsp_q.push_back(r);
        slave_q.push_back(d);
    endtask

    task automatic exp_mem(input logic [31:0] a, input logic we, input logic [3:0] sel,
                           input logic [31:0] wd, input logic [31:0] d, input int len);
        bus_t b;
        rsp_t r;
        b.addr = a; b.we = we; b.sel = sel; b.wdata = wd; b.chk_wd = 1'b1; b.len = len;
        r.port = 1'b1; r.rdata = d; r.err = 1'b0;
        bus_q.push_back(b);
        rsp_q.push_back(r);
        slave_q.push_back(d);
    endtask

    // Requester tasks start and end at posedge+1; req stays high through the ready cycle.
    task automatic do_if(input logic [31:0] a);
        int n;
        n = 0;
        if_addr = a;
        if_req  = 1'b1;
        forever begin
            @(negedge clk);
            if (if_ready) break;
            check("stall_if_wait", 32'(stallreq_if), 32'd1);
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL if_timeout: no if_ready after %0d cycles, expected completion", n);
                break;
            end
        end
        check("stall_if_ready", 32'(stallreq_if), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_mem(input logic [31:0] a, input logic we, input logic [3:0] sel,
                          input logic [31:0] wd);
        int n;
        n = 0;
        mem_addr  = a;
        mem_we    = we;
        mem_sel   = sel;
        mem_wdata = wd;
        mem_req   = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_ready) break;
            check("stall_mem_wait", 32'(stallreq_mem), 32'd1);
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL mem_timeout: no mem_ready after %0d cycles, expected completion", n);
                break;
            end
        end
        check("stall_mem_ready", 32'(stallreq_mem), 32'd0);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bus slave: acks after slave_wait wait cycles, returning queued data.
    initial begin
        int wcnt;
        wcnt = 0;
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (bus_req) begin
                if (wcnt >= slave_wait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = (slave_q.size() > 0) ? slave_q.pop_front() : 32'hBAD0_0000;
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Bus monitor: each new bus cycle must match the next expected transaction.
    initial begin
        bit   prev_req;
        int   cyc;
        bus_t cur;
        prev_req = 1'b0;
        cyc = 0;
        cur.addr = 32'd0; cur.we = 1'b0; cur.sel = 4'd0; cur.wdata = 32'd0; cur.chk_wd = 1'b0; cur.len = 0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bus_unexpected: bus cycle at addr 0x%h, expected none", bus_addr);
                    cur.addr = bus_addr; cur.we = bus_we; cur.sel = bus_sel; cur.len = 0;
                end else begin
                    cur = bus_q.pop_front();
                    check("bus_addr", bus_addr, cur.addr);
                    check("bus_we", 32'(bus_we), 32'(cur.we));
                    check("bus_sel", 32'(bus_sel), 32'(cur.sel));
                    if (cur.chk_wd) check("bus_wdata", bus_wdata, cur.wdata);
                end
                cyc = 1;
            end else if (bus_req) begin
                cyc++;
                check("bus_hold_addr", bus_addr, cur.addr);
                check("bus_hold_ctl", 32'({bus_we, bus_sel}), 32'({cur.we, cur.sel}));
            end
            if (!bus_req && prev_req && cur.len != 0)
                check("bus_req_len", 32'(cyc), 32'(cur.len));
            prev_req = bus_req;
        end
    end

    // Response monitor: every ready pulse must match the next expected response.
    initial begin
        bit   prev_rdy;
        bit   prev_ack;
        rsp_t r;
        prev_rdy = 1'b0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (if_ready || mem_ready) begin
                if (rsp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL ready_unexpected: if_ready=%0b mem_ready=%0b, expected none",
                             if_ready, mem_ready);
                end else begin
                    r = rsp_q.pop_front();
                    check("ready_excl", 32'(if_ready & mem_ready), 32'd0);
                    check("ready_port", 32'(mem_ready), 32'(r.port));
                    check("rdata", r.port ? mem_rdata : if_rdata, r.rdata);
                    check("bus_err", 32'(bus_err), 32'(r.err));
                    if (!r.err) check("ready_after_ack", 32'(prev_ack), 32'd1);
                    check("ready_pulse", 32'(prev_rdy), 32'd0);
                end
            end
            prev_rdy = if_ready | mem_ready;
            prev_ack = bus_ack & bus_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; slave_wait = 0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_stall_if", 32'(stallreq_if), 32'd0);
        check("rst_stall_mem", 32'(stallreq_mem), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // IF read, three slave wait cycles
        slave_wait = 3;
        exp_if(32'h0000_0100, 32'h2402_0005, 4);
        do_if(32'h0000_0100);
        idle(3);
        check("if_rdata_hold", if_rdata, 32'h2402_0005);

        // Simultaneous requests: MEM write goes first, then the IF read
        slave_wait = 1;
        exp_mem(32'h8000_0000, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h1111_2222, 2);
        exp_if(32'h0000_0104, 32'h8C08_0004, 2);
        fork
            do_mem(32'h8000_0000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
            do_if(32'h0000_0104);
        join
        idle(3);
        check("mem_rdata_hold", mem_rdata, 32'h1111_2222);

        // Zero-wait MEM read with a single byte enable
        slave_wait = 0;
        exp_mem(32'h8000_0010, 1'b0, 4'b1000, 32'h0, 32'h0000_00AB, 1);
        do_mem(32'h8000_0010, 1'b0, 4'b1000, 32'h0);
        idle(2);
        check("if_rdata_hold2", if_rdata, 32'h8C08_0004);

        // Back-to-back zero-wait IF reads
        exp_if(32'h0000_0200, 32'hA000_0200, 1);
        exp_if(32'h0000_0204, 32'hA000_0204, 1);
        do_if(32'h0000_0200);
        do_if(32'h0000_0204);
        idle(3);

        // Reset in the middle of a MEM grant
        slave_wait = 1000;
        begin
            bus_t b;
            b.addr = 32'h8000_0020; b.we = 1'b0; b.sel = 4'b1111; b.wdata = 32'h0;
            b.chk_wd = 1'b1; b.len = 0;
            bus_q.push_back(b);
        end
        mem_addr = 32'h8000_0020; mem_we = 1'b0; mem_sel = 4'b1111; mem_wdata = 32'h0;
        mem_req = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        mem_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_bus_req", 32'(bus_req), 32'd0);
        check("midrst_mem_ready", 32'(mem_ready), 32'd0);
        check("midrst_bus_addr", bus_addr, 32'd0);
        check("midrst_bus_sel", 32'(bus_sel), 32'd0);
        check("midrst_mem_rdata", mem_rdata, 32'd0);
        check("midrst_if_rdata", if_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        slave_wait = 2;
        exp_mem(32'h8000_0024, 1'b0, 4'b1111, 32'h0, 32'h5A5A_0001, 3);
        do_mem(32'h8000_0024, 1'b0, 4'b1111, 32'h0);
        idle(3);

`ifdef RISC32_ARB_TIMEOUT_EN
        // Slave never acks: abort after TO cycles with bus_err and zero data
        slave_wait = 1000;
        begin
            bus_t b;
            rsp_t r;
            b.addr = 32'h8000_0030; b.we = 1'b1; b.sel = 4'b1111; b.wdata = 32'h1234_5678;
            b.chk_wd = 1'b1; b.len = TO;
            r.port = 1'b1; r.rdata = 32'h0; r.err = 1'b1;
            bus_q.push_back(b);
            rsp_q.push_back(r);
        end
        do_mem(32'h8000_0030, 1'b1, 4'b1111, 32'h1234_5678);
        check("timeout_mem_rdata", mem_rdata, 32'h0);
        idle(3);
`endif

        idle(5);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
